cond_check_unit: RTL and testbench

- Consumer side of the NZCV flag interface in the ARMv7 datapath. The ALU decoder side produces and latches flags; this block owns the architectural NZCV register and evaluates each instruction's 4-bit cond field against it.
- Sits between decode and execute, using a valid/ready handshake on both sides.
- Tracks in-flight flag-setting instructions and stalls any conditional instruction until its flags are architecturally visible.

---
 rtl/cond_check_unit.sv | 126 ++++++++++++
 tb/tb_cond_check_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_check_unit.sv
// ARMv7 condition check: owns architectural NZCV, stalls conditionals on in-flight flag writers.
// Optional writeback bypass of flags into evaluation: define COND_FWD_EN.
module cond_check_unit #(
  parameter int MAX_PENDING = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Valid,
  output logic       o_Ready,
  input  logic [3:0] i_Cond,
  input  logic       i_SetFlags,
  input  logic       i_FlagWrEn,
  input  logic [3:0] i_Flags,
  output logic       o_Valid,
  input  logic       i_Ready,
  output logic       o_CondEx,
  output logic [3:0] o_Flags,
  output logic       o_Overflow
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [PW-1:0] pending;
  logic [3:0]    eval_flags;
  logic          fwd;
  logic          uncond;
  logic          hazard;
  logic          full;
  logic          eval;
  logic          issue;
  logic          inc;
  logic          dec;

  function automatic logic cond_pass(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy & !z;
      4'b1001: r = !cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    fwd = 1'b0;
`ifdef COND_FWD_EN
    fwd = (pending == PONE) & i_FlagWrEn;
`else
    fwd = 1'b0;
`endif
    uncond     = (i_Cond[3:1] == 3'b111);
    eval_flags = fwd ? i_Flags : o_Flags;
    hazard     = (pending != '0) & !uncond & !fwd;
    full       = (pending >= PMAX);
    o_Ready    = !hazard
               & (!full | !i_SetFlags)
               & (!o_Valid | i_Ready);
    eval       = cond_pass(i_Cond, eval_flags);
    issue      = i_Valid & o_Ready;
    inc        = issue & i_SetFlags & eval;
    dec        = i_FlagWrEn & (pending != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_Flags <= 4'b0000;
    end else if (i_FlagWrEn) begin
      o_Flags <= i_Flags;
    end
  end

  // Simultaneous issue-increment and writeback-decrement cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (inc & !dec) begin
      pending <= pending + PONE;
    end else if (dec & !inc) begin
      pending <= pending - PONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_Overflow <= 1'b0;
    end else if ((i_FlagWrEn & (pending == '0))
               | (inc & !dec & full)) begin
      o_Overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_Valid  <= 1'b0;
      o_CondEx <= 1'b0;
    end else if (issue) begin
      o_Valid  <= 1'b1;
      o_CondEx <= eval;
    end else if (o_Valid & i_Ready) begin
      o_Valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_check_unit.sv
// Directed bench for cond_check_unit: cond decode, hazard stalls,
// pending limit, backpressure, underflow and reset.
module tb_cond_check_unit;

  logic       clk;
  logic       reset;
  logic       i_Valid;
  logic       o_Ready;
  logic [3:0] i_Cond;
  logic       i_SetFlags;
  logic       i_FlagWrEn;
  logic [3:0] i_Flags;
  logic       o_Valid;
  logic       i_Ready;
  logic       o_CondEx;
  logic [3:0] o_Flags;
  logic       o_Overflow;

  int n_vec;
  int n_err;

  cond_check_unit #(.MAX_PENDING(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .i_Cond     (i_Cond),
    .i_SetFlags (i_SetFlags),
    .i_FlagWrEn (i_FlagWrEn),
    .i_Flags    (i_Flags),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_CondEx   (o_CondEx),
    .o_Flags    (o_Flags),
    .o_Overflow (o_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue_chk(input string tag, input logic [3:0] c,
                           input logic sf, input logic exp);
    i_Valid    = 1'b1;
    i_Cond     = c;
    i_SetFlags = sf;
    #1;
    chk({tag, "_rdy"}, {3'b0, o_Ready}, 4'd1);
    tick();
    i_Valid    = 1'b0;
    i_SetFlags = 1'b0;
    chk({tag, "_vld"}, {3'b0, o_Valid}, 4'd1);
    chk(tag, {3'b0, o_CondEx}, {3'b0, exp});
  endtask

  task automatic wb(input logic [3:0] f);
    i_FlagWrEn = 1'b1;
    i_Flags    = f;
    tick();
    i_FlagWrEn = 1'b0;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset      = 1'b1;
    i_Valid    = 1'b0;
    i_Cond     = 4'h0;
    i_SetFlags = 1'b0;
    i_FlagWrEn = 1'b0;
    i_Flags    = 4'h0;
    i_Ready    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", {3'b0, o_Valid}, 4'd0);
    chk("rst_condex", {3'b0, o_CondEx}, 4'd0);
    chk("rst_flags", o_Flags, 4'h0);
    chk("rst_ovf", {3'b0, o_Overflow}, 4'd0);

    // AL after reset
    issue_chk("al0", 4'hE, 1'b0, 1'b1);
    chk("al0_flags", o_Flags, 4'h0);
    chk("al0_ovf", {3'b0, o_Overflow}, 4'd0);

    // Z=1
    issue_chk("als1", 4'hE, 1'b1, 1'b1);
    wb(4'b0100);
    chk("wb_z_flags", o_Flags, 4'b0100);
    chk("wb_z_ovf", {3'b0, o_Overflow}, 4'd0);
    issue_chk("eq_z", 4'h0, 1'b0, 1'b1);
    issue_chk("ne_z", 4'h1, 1'b0, 1'b0);
    issue_chk("gt_z", 4'hC, 1'b0, 1'b0);
    issue_chk("le_z", 4'hD, 1'b0, 1'b1);
    issue_chk("ls_z", 4'h9, 1'b0, 1'b1);

    // N=1 V=1
    issue_chk("als2", 4'hE, 1'b1, 1'b1);
    wb(4'b1001);
    issue_chk("ge_nv", 4'hA, 1'b0, 1'b1);
    issue_chk("lt_nv", 4'hB, 1'b0, 1'b0);
    issue_chk("mi_nv", 4'h4, 1'b0, 1'b1);
    issue_chk("vc_nv", 4'h7, 1'b0, 1'b0);

    // C=1
    issue_chk("als3", 4'hE, 1'b1, 1'b1);
    wb(4'b0010);
    issue_chk("hi_c", 4'h8, 1'b0, 1'b1);
    issue_chk("cc_c", 4'h3, 1'b0, 1'b0);
    issue_chk("pl_c", 4'h5, 1'b0, 1'b1);
    issue_chk("vs_c", 4'h6, 1'b0, 1'b0);
    issue_chk("nv_c", 4'hF, 1'b0, 1'b1);

    // Hazard: flag-setter then EQ; flags are 0010 (Z=0)
    issue_chk("hz_set", 4'hE, 1'b1, 1'b1);
    i_Valid = 1'b1;
    i_Cond  = 4'h0;
    #1;
    chk("hz_stall0", {3'b0, o_Ready}, 4'd0);
    tick();
    chk("hz_stall1", {3'b0, o_Ready}, 4'd0);
    chk("hz_drain", {3'b0, o_Valid}, 4'd0);
    i_FlagWrEn = 1'b1;
    i_Flags    = 4'b0100;
    #1;
`ifdef COND_FWD_EN
    chk("hz_fwd_rdy", {3'b0, o_Ready}, 4'd1);
    tick();
    i_FlagWrEn = 1'b0;
    i_Valid    = 1'b0;
`else
    chk("hz_wb_rdy", {3'b0, o_Ready}, 4'd0);
    tick();
    i_FlagWrEn = 1'b0;
    #1;
    chk("hz_post_rdy", {3'b0, o_Ready}, 4'd1);
    tick();
    i_Valid = 1'b0;
`endif
    chk("hz_vld", {3'b0, o_Valid}, 4'd1);
    chk("hz_eq", {3'b0, o_CondEx}, 4'd1);
    chk("hz_ovf", {3'b0, o_Overflow}, 4'd0);

    // Pending limit of 2
    issue_chk("mp1", 4'hE, 1'b1, 1'b1);
    issue_chk("mp2", 4'hE, 1'b1, 1'b1);
    i_Valid    = 1'b1;
    i_Cond     = 4'hE;
    i_SetFlags = 1'b1;
    #1;
    chk("mp3_stall0", {3'b0, o_Ready}, 4'd0);
    tick();
    chk("mp3_stall1", {3'b0, o_Ready}, 4'd0);
    i_FlagWrEn = 1'b1;
    i_Flags    = 4'b0000;
    #1;
    chk("mp3_wbcyc", {3'b0, o_Ready}, 4'd0);
    tick();
    i_FlagWrEn = 1'b0;
    #1;
    chk("mp3_rdy", {3'b0, o_Ready}, 4'd1);
    tick();
    chk("mp3_vld", {3'b0, o_Valid}, 4'd1);
    chk("mp3_cex", {3'b0, o_CondEx}, 4'd1);
    #1;
    chk("mp4_stall", {3'b0, o_Ready}, 4'd0);
    i_Valid    = 1'b0;
    i_SetFlags = 1'b0;
    wb(4'b0000);
    wb(4'b0000);
    chk("mp_ovf", {3'b0, o_Overflow}, 4'd0);

    // Backpressure; flags 0000
    issue_chk("bp_ne", 4'h1, 1'b0, 1'b1);
    i_Ready = 1'b0;
    i_Valid = 1'b1;
    i_Cond  = 4'h0;
    #1;
    chk("bp_rdy0", {3'b0, o_Ready}, 4'd0);
    tick();
    chk("bp_hold_v", {3'b0, o_Valid}, 4'd1);
    chk("bp_hold_c", {3'b0, o_CondEx}, 4'd1);
    tick();
    chk("bp_hold_c2", {3'b0, o_CondEx}, 4'd1);
    i_Ready = 1'b1;
    #1;
    chk("bp_rdy1", {3'b0, o_Ready}, 4'd1);
    tick();
    i_Valid = 1'b0;
    chk("bp_next_v", {3'b0, o_Valid}, 4'd1);
    chk("bp_next_c", {3'b0, o_CondEx}, 4'd0);

    // Underflow writeback
    wb(4'b1010);
    chk("uf_ovf", {3'b0, o_Overflow}, 4'd1);
    chk("uf_flags", o_Flags, 4'b1010);
    tick();
    chk("uf_sticky", {3'b0, o_Overflow}, 4'd1);

    // Reset with one pending
    issue_chk("rs_set", 4'hE, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_valid", {3'b0, o_Valid}, 4'd0);
    chk("rs_flags", o_Flags, 4'h0);
    chk("rs_ovf", {3'b0, o_Overflow}, 4'd0);
    issue_chk("rs_eq", 4'h0, 1'b0, 1'b0);
    wb(4'b0011);
    chk("rs_uf_ovf", {3'b0, o_Overflow}, 4'd1);
    chk("rs_uf_flags", o_Flags, 4'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
